dispatch_queue: RTL and testbench
=================================

// Module: dispatch_queue
// PURPOSE
//  Parametrised dispatch stage between rename and the issue queues. It buffers up to WIDTH renamed uops
//  per cycle in an in-order ring of DEPTH entries. Each cycle it dispatches up to 2 of the oldest uops,
//  one to the ALU IQ and one to the LSU IQ, stamping each with a ROB index ({flag,idx}).
//  Handles ROB-full back-pressure, non-IDLE ROB state stalls and redirect flush.
// PARAMETERS
//  WIDTH         2   uops accepted per cycle from rename (all-or-nothing group)
//  DEPTH         8   ring entries; power of 2, DEPTH >= 2*WIDTH
//  PAYLOAD_W     160 opaque renamed-uop payload bits (pregs, imm, pc, types ...)
//  ROB_SIZE_LOG  6   log2 ROB entries; ROB index = {flag, idx[ROB_SIZE_LOG-1:0]}
// PORTS
//  clock             in  1                   system clock
//  reset_n           in  1                   synchronous, active-low reset
//  in_valid          in  WIDTH               per-lane valid; valid lanes form a prefix (lane0 oldest)
//  in_ready          out 1                   group accepted when in_ready & |in_valid
//  in_payload        in  WIDTH*PAYLOAD_W     lane i at [i*PAYLOAD_W +: PAYLOAD_W]
//  in_is_mem         in  WIDTH               1 = load/store -> LSU IQ, 0 -> ALU IQ
//  alu_valid         out 1                   uop offered to ALU IQ
//  alu_ready         in  1                   ALU IQ can accept
//  alu_payload       out PAYLOAD_W           payload of the offered uop
//  alu_robidx_flag   out 1                   ROB wrap flag of the offered uop
//  alu_robidx        out ROB_SIZE_LOG        ROB index of the offered uop
//  lsu_valid/ready/payload/robidx_flag/robidx  same as the alu_* group, for the LSU IQ
//  rob_enq_robidx_flag in 1                  ROB tail flag
//  rob_enq_robidx    in  ROB_SIZE_LOG        ROB tail index
//  rob_free_cnt      in  ROB_SIZE_LOG+1      free ROB entries (0..2^ROB_SIZE_LOG)
//  rob_state         in  2                   dispatch only when == ROB_STATE_IDLE
//  rob_enq_cnt       out 2                   uops dispatched this cycle (0..2); ROB advances tail by this
//  flush_valid       in  1                   redirect flush; every buffered uop is younger than the flush point
//  occupancy         out $clog2(DEPTH)+1     registered entry count
// BEHAVIOUR
//  - Reset (reset_n=0 at a clock edge): head=tail=0, count=0. Reset is synchronous and active-low.
//    While in reset and the cycle after: all *_valid=0, rob_enq_cnt=0, in_ready=0 during reset, occupancy=0.
//  - Pointers are $clog2(DEPTH)+1 bits with a wrap bit. count = tail - head.
//  - Enqueue
//    - in_ready = ~flush_valid & (DEPTH - count >= WIDTH). Uses the current count; same-cycle dequeues are ignored.
//    - On accept, popcount(in_valid) entries are written at tail in lane order; tail += popcount.
//  - Dispatch (combinational from registered ring state)
//    - go = (rob_state==ROB_STATE_IDLE) & ~flush_valid.
//    - h0 = oldest entry, h1 = next entry. tgt(h) = is_mem ? LSU : ALU.
//    - d0 = go & count>=1 & rob_free_cnt>=1; h0 is offered on port tgt(h0) when d0.
//    - h0 fires when the valid and ready of its target port are both 1.
//    - h1 is offered on port tgt(h1) only when: h0 fires, count>=2, rob_free_cnt>=2 and tgt(h1)!=tgt(h0).
//      This makes the second lane's valid depend on the other port's ready; the IQs must not loop ready on valid.
//    - h1 never bypasses h0. Strict program order.
//    - robidx(h0) = {rob_enq_robidx_flag, rob_enq_robidx}; robidx(h1) = that value + 1, computed at
//      ROB_SIZE_LOG+1 bits, so the flag toggles on wrap.
//    - rob_enq_cnt = number of fires; head += rob_enq_cnt.
//  - Latency: an uop enqueued in cycle N is offered no earlier than cycle N+1 (no enqueue->dispatch bypass).
//  - Simultaneous enqueue and dispatch: count_next = count + enq_n - deq_n. Full and empty are never violated.
//  - flush_valid=1: no enqueue, all valids=0, rob_enq_cnt=0. At the clock edge head<=tail, i.e. empty next cycle.
//    Flush has priority over every other event.
//  - rob_state != IDLE (walk/recovery): ring holds its contents; enqueue continues while space remains.
//  - rob_free_cnt==0 or both IQs not ready: no dispatch, contents held, no payload change.
// STRUCTURE
//  - dispatch_pkg:
//    - ROB_STATE_IDLE and the other rob_state encodings
//    - typedef enum {TGT_ALU, TGT_LSU} disp_tgt_t
//    - typedef struct {payload, is_mem} disp_entry_t
//  - One sub-module: dispatch_ring (parametrised circular buffer).
//    - Multi-write of up to WIDTH, read of two oldest, pop 0..2, clear.
//  - dispatch_queue holds the steering, ROB-index and back-pressure logic.
// TESTING
//  1. Reset, then 2 ALU uops (A,B) in one group, rob tail=5, alu_ready=1: cycle+1 A on ALU with robidx 5, rob_enq_cnt=1;
//     cycle+2 B with robidx 6; occupancy 2->1->0.
//  2. ALU then LSU pair, both ready, tail=5: same cycle alu robidx=5, lsu robidx=6, rob_enq_cnt=2.
//     Repeat with alu_ready=0: nothing fires, including the LSU uop.
//  3. Wrap: tail={0,63} (ROB_SIZE_LOG=6), ALU+LSU pair -> lane0 {0,63}, lane1 {1,0}.
//     rob_free_cnt=1 -> only lane0 fires.
//  4. Fill: DEPTH=8, hold both IQ readies low, push 2-wide groups -> in_ready=0 once count=7;
//     a single alu fire does not raise in_ready that cycle; it rises the next cycle (count=6).
//  5. Flush with 5 entries plus a concurrent enqueue attempt -> that cycle all valids=0 and in_ready=0;
//     next cycle occupancy=0. rob_state=WALK for 3 cycles -> no dispatch, contents intact, resume in order.
//  6. reset_n low for one cycle mid-stream with 4 entries -> next cycle occupancy=0 and all valids=0.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types for the rename->issue dispatch stage: ROB state encodings,
// issue-queue target selector and the buffered uop record.
package dispatch_pkg;

    typedef enum logic [1:0] {
        ROB_STATE_IDLE    = 2'd0,
        ROB_STATE_WALK    = 2'd1,
        ROB_STATE_REPLAY  = 2'd2,
        ROB_STATE_RECOVER = 2'd3
    } rob_state_t;

    typedef enum logic {
        TGT_ALU = 1'b0,
        TGT_LSU = 1'b1
    } disp_tgt_t;

    localparam int DISP_PAYLOAD_W = 160;

    typedef struct packed {
        logic [DISP_PAYLOAD_W-1:0] payload;
        logic                      is_mem;
    } disp_entry_t;

    function automatic disp_tgt_t tgt_of(input logic is_mem);
        return is_mem ? TGT_LSU : TGT_ALU;
    endfunction

endpackage

// File: rtl/dispatch_ring.sv
// In-order circular buffer: writes up to WIDTH prefix lanes at tail, exposes the
// two oldest entries, pops 0..2 per cycle and can be cleared in one cycle.
module dispatch_ring
    import dispatch_pkg::*;
#(
    parameter  int ENTRY_W = DISP_PAYLOAD_W + 1,
    parameter  int WIDTH   = 2,
    parameter  int DEPTH   = 8,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int PTR_W   = IDX_W + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_valid_i,
    input  logic [WIDTH*ENTRY_W-1:0] wr_data_i,
    input  logic [1:0]               pop_i,
    output logic [ENTRY_W-1:0]       rd0_o,
    output logic [ENTRY_W-1:0]       rd1_o,
    output logic [PTR_W-1:0]         count_o
);

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]   wr_idx [WIDTH];
    logic [PTR_W-1:0]   wr_n;

    always_comb begin
        wr_n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wr_idx[i] = IDX_W'(tail_q + PTR_W'(i));
            wr_n      = wr_n + PTR_W'(wr_valid_i[i]);
        end
    end

    // Clear collapses the ring by pulling head up to tail; the owner never writes on a clear cycle.
    always_comb begin
        head_d = head_q + PTR_W'(pop_i);
        tail_d = tail_q + (wr_en_i ? wr_n : '0);
        if (clear_i) begin
            head_d = tail_q;
            tail_d = tail_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (wr_valid_i[i]) begin
                    mem_q[wr_idx[i]] <= wr_data_i[i*ENTRY_W +: ENTRY_W];
                end
            end
        end
    end

    assign rd0_o   = mem_q[IDX_W'(head_q)];
    assign rd1_o   = mem_q[IDX_W'(head_q + PTR_W'(1))];
    assign count_o = tail_q - head_q;

endmodule

// File: rtl/dispatch_queue.sv
// Dispatch stage between rename and the issue queues: buffers renamed uops and
// issues the two oldest in order to the ALU/LSU IQs, stamping ROB indices.
module dispatch_queue
    import dispatch_pkg::*;
#(
    parameter  int WIDTH        = 2,
    parameter  int DEPTH        = 8,
    parameter  int PAYLOAD_W    = 160,
    parameter  int ROB_SIZE_LOG = 6,
    localparam int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           in_valid,
    output logic                       in_ready,
    input  logic [WIDTH*PAYLOAD_W-1:0] in_payload,
    input  logic [WIDTH-1:0]           in_is_mem,
    output logic                       alu_valid,
    input  logic                       alu_ready,
    output logic [PAYLOAD_W-1:0]       alu_payload,
    output logic                       alu_robidx_flag,
    output logic [ROB_SIZE_LOG-1:0]    alu_robidx,
    output logic                       lsu_valid,
    input  logic                       lsu_ready,
    output logic [PAYLOAD_W-1:0]       lsu_payload,
    output logic                       lsu_robidx_flag,
    output logic [ROB_SIZE_LOG-1:0]    lsu_robidx,
    input  logic                       rob_enq_robidx_flag,
    input  logic [ROB_SIZE_LOG-1:0]    rob_enq_robidx,
    input  logic [ROB_SIZE_LOG:0]      rob_free_cnt,
    input  logic [1:0]                 rob_state,
    output logic [1:0]                 rob_enq_cnt,
    input  logic                       flush_valid,
    output logic [CNT_W-1:0]           occupancy
);

    localparam int ENTRY_W = PAYLOAD_W + 1;
    localparam int RI_W    = ROB_SIZE_LOG + 1;

    logic [WIDTH*ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0]       rd0, rd1;
    logic [CNT_W-1:0]         count;
    logic                     wr_en;

    disp_tgt_t                tgt0, tgt1;
    logic                     go, d0, d1, rdy0, rdy1, fire0, fire1;
    logic                     alu_h1, lsu_h1;
    logic [RI_W-1:0]          ri0, ri1;

    for (genvar g = 0; g < WIDTH; g++) begin : g_pack
        assign wr_data[g*ENTRY_W +: ENTRY_W] = {in_is_mem[g], in_payload[g*PAYLOAD_W +: PAYLOAD_W]};
    end

    dispatch_ring #(
        .ENTRY_W (ENTRY_W),
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH)
    ) u_ring (
        .clk_i      (clock),
        .rst_n_i    (reset_n),
        .clear_i    (flush_valid),
        .wr_en_i    (wr_en),
        .wr_valid_i (in_valid),
        .wr_data_i  (wr_data),
        .pop_i      (rob_enq_cnt),
        .rd0_o      (rd0),
        .rd1_o      (rd1),
        .count_o    (count)
    );

    // Space check uses the registered count only; same-cycle dequeues do not free room.
    assign in_ready  = reset_n & ~flush_valid & (count <= CNT_W'(DEPTH - WIDTH));
    assign wr_en     = in_ready & (|in_valid);
    assign occupancy = reset_n ? count : '0;

    assign go    = reset_n & (rob_state == ROB_STATE_IDLE) & ~flush_valid;
    assign tgt0  = tgt_of(rd0[ENTRY_W-1]);
    assign tgt1  = tgt_of(rd1[ENTRY_W-1]);

    assign d0    = go & (count != '0) & (rob_free_cnt != '0);
    assign rdy0  = (tgt0 == TGT_LSU) ? lsu_ready : alu_ready;
    assign fire0 = d0 & rdy0;

    // The younger uop rides along only behind a firing oldest uop, on the other port.
    assign d1    = fire0 & (count >= CNT_W'(2)) & (rob_free_cnt >= RI_W'(2)) & (tgt1 != tgt0);
    assign rdy1  = (tgt1 == TGT_LSU) ? lsu_ready : alu_ready;
    assign fire1 = d1 & rdy1;

    assign ri0   = {rob_enq_robidx_flag, rob_enq_robidx};
    assign ri1   = ri0 + RI_W'(1);

    assign alu_h1 = d1 & (tgt1 == TGT_ALU);
    assign lsu_h1 = d1 & (tgt1 == TGT_LSU);

    assign alu_valid   = (d0 & (tgt0 == TGT_ALU)) | alu_h1;
    assign alu_payload = alu_h1 ? rd1[PAYLOAD_W-1:0] : rd0[PAYLOAD_W-1:0];
    assign {alu_robidx_flag, alu_robidx} = alu_h1 ? ri1 : ri0;

    assign lsu_valid   = (d0 & (tgt0 == TGT_LSU)) | lsu_h1;
    assign lsu_payload = lsu_h1 ? rd1[PAYLOAD_W-1:0] : rd0[PAYLOAD_W-1:0];
    assign {lsu_robidx_flag, lsu_robidx} = lsu_h1 ? ri1 : ri0;

    assign rob_enq_cnt = 2'(fire0) + 2'(fire1);

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomised scoreboard bench for dispatch_queue: a queue-based reference model
// predicts every cycle's outputs, a separate monitor compares them.
module tb_dispatch_queue;
    import dispatch_pkg::*;

    localparam int WIDTH = 2;
    localparam int DEPTH = 8;
    localparam int PW    = 160;
    localparam int RSL   = 6;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [WIDTH-1:0]      in_valid;
    logic                  in_ready;
    logic [WIDTH*PW-1:0]   in_payload;
    logic [WIDTH-1:0]      in_is_mem;
    logic                  alu_valid, alu_ready, alu_robidx_flag;
    logic [PW-1:0]         alu_payload;
    logic [RSL-1:0]        alu_robidx;
    logic                  lsu_valid, lsu_ready, lsu_robidx_flag;
    logic [PW-1:0]         lsu_payload;
    logic [RSL-1:0]        lsu_robidx;
    logic                  rob_enq_robidx_flag;
    logic [RSL-1:0]        rob_enq_robidx;
    logic [RSL:0]          rob_free_cnt;
    logic [1:0]            rob_state;
    logic [1:0]            rob_enq_cnt;
    logic                  flush_valid;
    logic [3:0]            occupancy;

    dispatch_queue #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PAYLOAD_W(PW), .ROB_SIZE_LOG(RSL)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload), .in_is_mem(in_is_mem),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_payload(alu_payload),
        .alu_robidx_flag(alu_robidx_flag), .alu_robidx(alu_robidx),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_payload(lsu_payload),
        .lsu_robidx_flag(lsu_robidx_flag), .lsu_robidx(lsu_robidx),
        .rob_enq_robidx_flag(rob_enq_robidx_flag), .rob_enq_robidx(rob_enq_robidx),
        .rob_free_cnt(rob_free_cnt), .rob_state(rob_state), .rob_enq_cnt(rob_enq_cnt),
        .flush_valid(flush_valid), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          alu_v;
        logic [PW-1:0] alu_pl;
        logic [6:0]    alu_ri;
        logic          lsu_v;
        logic [PW-1:0] lsu_pl;
        logic [6:0]    lsu_ri;
        logic [1:0]    cnt;
        logic          rdy;
        logic [3:0]    occ;
    } exp_t;

    exp_t        exp_q[$];
    disp_entry_t mq[$];
    logic [6:0]  tail_ptr = 7'd0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [PW-1:0] rnd_pl();
        logic [PW-1:0] p;
        for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs from the buffered uop list,
    // then advance the model to the state after the coming clock edge.
    task automatic step(input logic r, input logic [1:0] v, input logic [1:0] m,
                        input logic ar, input logic lr, input int free,
                        input logic [1:0] rs, input logic fl);
        exp_t          e;
        disp_entry_t   ent;
        logic [PW-1:0] p0, p1;
        int            n, base;
        logic          h0rdy;
        p0 = rnd_pl();
        p1 = rnd_pl();
        reset_n = r; in_valid = v; in_is_mem = m; in_payload = {p1, p0};
        alu_ready = ar; lsu_ready = lr; rob_free_cnt = 7'(free);
        rob_state = rs; flush_valid = fl;
        rob_enq_robidx_flag = tail_ptr[6];
        rob_enq_robidx = tail_ptr[5:0];

        e = '0;
        n = mq.size();
        base = int'(tail_ptr);
        e.rdy = r && !fl && (DEPTH - n >= WIDTH);
        e.occ = r ? 4'(n) : 4'd0;
        if (r && rs == ROB_STATE_IDLE && !fl && n >= 1 && free >= 1) begin
            if (mq[0].is_mem) begin
                e.lsu_v = 1'b1; e.lsu_pl = mq[0].payload; e.lsu_ri = 7'(base); h0rdy = lr;
            end else begin
                e.alu_v = 1'b1; e.alu_pl = mq[0].payload; e.alu_ri = 7'(base); h0rdy = ar;
            end
            if (h0rdy) begin
                e.cnt = 2'd1;
                if (n >= 2 && free >= 2 && mq[1].is_mem != mq[0].is_mem) begin
                    if (mq[1].is_mem) begin
                        e.lsu_v = 1'b1; e.lsu_pl = mq[1].payload; e.lsu_ri = 7'((base + 1) % 128);
                        if (lr) e.cnt = 2'd2;
                    end else begin
                        e.alu_v = 1'b1; e.alu_pl = mq[1].payload; e.alu_ri = 7'((base + 1) % 128);
                        if (ar) e.cnt = 2'd2;
                    end
                end
            end
        end
        exp_q.push_back(e);

        if (!r || fl) begin
            mq.delete();
        end else begin
            repeat (int'(e.cnt)) void'(mq.pop_front());
            if (e.rdy) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (v[i]) begin
                        ent.payload = (i == 0) ? p0 : p1;
                        ent.is_mem  = m[i];
                        mq.push_back(ent);
                    end
                end
            end
        end
        tail_ptr = 7'((base + int'(e.cnt)) % 128);
        @(posedge clock);
        #1;
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("alu_valid", PW'(alu_valid), PW'(x.alu_v));
                chk("lsu_valid", PW'(lsu_valid), PW'(x.lsu_v));
                chk("rob_enq_cnt", PW'(rob_enq_cnt), PW'(x.cnt));
                chk("in_ready", PW'(in_ready), PW'(x.rdy));
                chk("occupancy", PW'(occupancy), PW'(x.occ));
                if (x.alu_v) begin
                    chk("alu_payload", alu_payload, x.alu_pl);
                    chk("alu_robidx", PW'({alu_robidx_flag, alu_robidx}), PW'(x.alu_ri));
                end
                if (x.lsu_v) begin
                    chk("lsu_payload", lsu_payload, x.lsu_pl);
                    chk("lsu_robidx", PW'({lsu_robidx_flag, lsu_robidx}), PW'(x.lsu_ri));
                end
            end
        end
    end

    localparam logic [1:0] I = ROB_STATE_IDLE;
    localparam logic [1:0] W = ROB_STATE_WALK;

    initial begin
        int         k, free;
        logic [1:0] v, rs;
        reset_n = 1'b0; in_valid = '0; in_payload = '0; in_is_mem = '0;
        alu_ready = 1'b0; lsu_ready = 1'b0; rob_enq_robidx_flag = 1'b0; rob_enq_robidx = '0;
        rob_free_cnt = '0; rob_state = I; flush_valid = 1'b0;
        @(posedge clock);
        #1;

        repeat (2) step(0, 2'b00, 2'b00, 0, 0, 64, I, 0);
        // two ALU uops, tail 5
        tail_ptr = 7'd5;
        step(1, 2'b11, 2'b00, 1, 1, 64, I, 0);
        repeat (3) step(1, 2'b00, 2'b00, 1, 1, 64, I, 0);
        // ALU+LSU pair, then blocked by alu_ready=0
        tail_ptr = 7'd5;
        step(1, 2'b11, 2'b10, 1, 1, 64, I, 0);
        step(1, 2'b00, 2'b00, 1, 1, 64, I, 0);
        step(1, 2'b11, 2'b10, 0, 1, 64, I, 0);
        repeat (2) step(1, 2'b00, 2'b00, 0, 1, 64, I, 0);
        step(1, 2'b00, 2'b00, 1, 1, 64, I, 0);
        // ROB index wrap and single free entry
        tail_ptr = 7'd63;
        step(1, 2'b11, 2'b10, 1, 1, 64, I, 0);
        step(1, 2'b00, 2'b00, 1, 1, 64, I, 0);
        step(1, 2'b11, 2'b10, 1, 1, 1, I, 0);
        step(1, 2'b00, 2'b00, 1, 1, 1, I, 0);
        step(1, 2'b00, 2'b00, 1, 1, 64, I, 0);
        step(1, 2'b00, 2'b00, 1, 1, 0, I, 0);
        step(1, 2'b00, 2'b00, 1, 1, 64, I, 0);
        // fill to 7, then one ALU fire
        repeat (3) step(1, 2'b11, 2'b00, 0, 0, 64, I, 0);
        step(1, 2'b01, 2'b00, 0, 0, 64, I, 0);
        step(1, 2'b11, 2'b00, 0, 0, 64, I, 0);
        step(1, 2'b11, 2'b00, 1, 0, 64, I, 0);
        step(1, 2'b11, 2'b00, 0, 0, 64, I, 0);
        repeat (9) step(1, 2'b00, 2'b00, 1, 1, 64, I, 0);
        // flush with 5 entries and a concurrent enqueue, then ROB walk
        repeat (2) step(1, 2'b11, 2'b01, 0, 0, 64, I, 0);
        step(1, 2'b01, 2'b00, 0, 0, 64, I, 0);
        step(1, 2'b11, 2'b11, 1, 1, 64, I, 1);
        step(1, 2'b00, 2'b00, 1, 1, 64, I, 0);
        repeat (2) step(1, 2'b11, 2'b10, 0, 0, 64, I, 0);
        repeat (3) step(1, 2'b01, 2'b01, 1, 1, 64, W, 0);
        repeat (6) step(1, 2'b00, 2'b00, 1, 1, 64, I, 0);
        // reset mid-stream with 4 entries
        repeat (2) step(1, 2'b11, 2'b10, 0, 0, 64, I, 0);
        step(0, 2'b00, 2'b00, 1, 1, 64, I, 0);
        step(1, 2'b00, 2'b00, 1, 1, 64, I, 0);

        for (int c = 0; c < 3000; c++) begin
            k = $urandom_range(0, 2);
            v = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
            free = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 64);
            rs = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : I;
            if ($urandom_range(0, 49) == 0) tail_ptr = 7'($urandom);
            step($urandom_range(0, 199) != 0, v, 2'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, free, rs,
                 $urandom_range(0, 29) == 0);
        end
        repeat (12) step(1, 2'b00, 2'b00, 1, 1, 64, I, 0);

        @(negedge clock);
        #1;
        chk("scoreboard_drained", PW'(exp_q.size()), PW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
